// File: rtl/apb_i2c_pkg.sv
// Shared constants and state encodings for the APB-to-I2C write sequencer.
// Optional feature macro used by this slice: APB_SEQ_TIMEOUT_EN.
package apb_i2c_pkg;

    localparam int REG_CTRL    = 2;
    localparam int REG_TXDATA  = 4;
    localparam int REG_SLVADDR = 6;

    localparam logic [7:0] CTRL_RESET  = 8'hF6;
    localparam logic [7:0] CTRL_ENABLE = 8'hFC;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CTRL_RST,
        S_SLV_ADDR,
        S_DATA,
        S_CTRL_EN
    } step_t;

    typedef enum logic [1:0] {
        X_IDLE,
        X_SETUP,
        X_ACCESS,
        X_GAP
    } xfer_t;

endpackage

// File: rtl/apb_master_xfer.sv
// Single two-phase APB write engine: SETUP, ACCESS, GAP.
// APB_SEQ_TIMEOUT_EN adds an ACCESS-phase watchdog of TIMEOUT cycles.
module apb_master_xfer
    import apb_i2c_pkg::*;
#(
    parameter int ADDRESSWIDTH = 4,
    parameter int DATAWIDTH    = 8,
    parameter int TIMEOUT      = 64
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    go,
    input  logic [ADDRESSWIDTH-1:0] addr,
    input  logic [DATAWIDTH-1:0]    wdata,
    output logic                    free,
    output logic                    ack,
    output logic                    timeout,
    output logic [ADDRESSWIDTH-1:0] PADDR,
    output logic [DATAWIDTH-1:0]    PWDATA,
    output logic                    PWRITE,
    output logic                    PSELx,
    output logic                    PENABLE,
    input  logic                    PREADY
);

    xfer_t                   state, state_nxt;
    logic [ADDRESSWIDTH-1:0] addr_q, addr_nxt;
    logic [DATAWIDTH-1:0]    data_q, data_nxt;
    logic                    expired;

`ifdef APB_SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;

    always_ff @(posedge PCLK) begin
        if (!PRESETn || state != X_ACCESS) cnt <= '0;
        else if (!PREADY)                   cnt <= cnt + CW'(1);
    end

    assign expired = !PREADY && (cnt == CW'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign expired        = 1'b0;
`endif

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state  <= X_IDLE;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            state  <= state_nxt;
            addr_q <= addr_nxt;
            data_q <= data_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr_q;
        data_nxt  = data_q;
        ack       = 1'b0;
        timeout   = 1'b0;
        case (state)
            X_IDLE, X_GAP: begin
                if (go) begin
                    state_nxt = X_SETUP;
                    addr_nxt  = addr;
                    data_nxt  = wdata;
                end else begin
                    state_nxt = X_IDLE;
                end
            end
            X_SETUP: state_nxt = X_ACCESS;
            X_ACCESS: begin
                if (PREADY) begin
                    ack       = 1'b1;
                    state_nxt = X_GAP;
                end else if (expired) begin
                    timeout   = 1'b1;
                    state_nxt = X_GAP;
                end
            end
            default: state_nxt = X_IDLE;
        endcase
    end

    assign free    = (state == X_IDLE) || (state == X_GAP);
    assign PSELx   = (state == X_SETUP) || (state == X_ACCESS);
    assign PENABLE = (state == X_ACCESS);
    assign PWRITE  = PSELx;
    assign PADDR   = addr_q;
    assign PWDATA  = data_q;

endmodule

// File: rtl/apb_i2c_sequencer.sv
// Buffers payload bytes and drives one I2C write through the bridge's APB port.
// APB_SEQ_TIMEOUT_EN enables the ACCESS watchdog inside apb_master_xfer.
module apb_i2c_sequencer
    import apb_i2c_pkg::*;
#(
    parameter int ADDRESSWIDTH = 4,
    parameter int DATAWIDTH    = 8,
    parameter int DEPTH        = 8,
    parameter int TIMEOUT      = 64
) (
    input  logic                     PCLK,
    input  logic                     PRESETn,
    input  logic                     byte_valid,
    input  logic [DATAWIDTH-1:0]     byte_data,
    output logic                     byte_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    input  logic                     start,
    input  logic [DATAWIDTH-1:0]     slave_addr,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [ADDRESSWIDTH-1:0]  PADDR,
    output logic [DATAWIDTH-1:0]     PWDATA,
    output logic                     PWRITE,
    output logic                     PSELx,
    output logic                     PENABLE,
    input  logic                     PREADY,
    input  logic [DATAWIDTH-1:0]     PRDATA
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATAWIDTH-1:0]    mem [DEPTH];
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [LW-1:0]           level;
    logic [DATAWIDTH-1:0]    slv_q;
    step_t                   step, step_nxt;
    logic                    done_nxt, error_nxt;
    logic                    start_ok, push, pop, flush, full;
    logic                    go, ack, timeout, free;
    logic [ADDRESSWIDTH-1:0] go_addr;
    logic [DATAWIDTH-1:0]    go_data;

    logic unused_prdata;
    assign unused_prdata = ^PRDATA;

    assign busy       = (step != S_IDLE);
    assign full       = (level == LW'(DEPTH));
    assign byte_ready = !busy && !full;
    assign fifo_level = level;
    assign start_ok   = start && !busy && (level != '0);
    // A byte offered alongside the accepted start would race the sequence.
    assign push       = byte_valid && byte_ready && !start_ok;
    assign go         = busy ? free : start_ok;

    always_comb begin
        step_nxt  = step;
        done_nxt  = 1'b0;
        error_nxt = 1'b0;
        pop       = 1'b0;
        flush     = 1'b0;
        go_addr   = ADDRESSWIDTH'(REG_CTRL);
        go_data   = DATAWIDTH'(CTRL_RESET);
        case (step)
            S_IDLE: begin
                if (start_ok)   step_nxt  = S_CTRL_RST;
                else if (start) error_nxt = 1'b1;
            end
            S_CTRL_RST: begin
                if (ack) step_nxt = S_SLV_ADDR;
            end
            S_SLV_ADDR: begin
                go_addr = ADDRESSWIDTH'(REG_SLVADDR);
                go_data = slv_q;
                if (ack) step_nxt = S_DATA;
            end
            S_DATA: begin
                go_addr = ADDRESSWIDTH'(REG_TXDATA);
                go_data = mem[rd_ptr];
                if (ack) begin
                    pop = 1'b1;
                    if (level == LW'(1)) step_nxt = S_CTRL_EN;
                end
            end
            S_CTRL_EN: begin
                go_data = DATAWIDTH'(CTRL_ENABLE);
                if (ack) begin
                    step_nxt = S_IDLE;
                    done_nxt = 1'b1;
                end
            end
            default: step_nxt = S_IDLE;
        endcase
        if (timeout) begin
            step_nxt  = S_IDLE;
            flush     = 1'b1;
            error_nxt = 1'b1;
            done_nxt  = 1'b0;
            pop       = 1'b0;
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            step   <= S_IDLE;
            done   <= 1'b0;
            error  <= 1'b0;
            slv_q  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            step  <= step_nxt;
            done  <= done_nxt;
            error <= error_nxt;
            if (start_ok) slv_q <= slave_addr;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                level <= level + LW'(push) - LW'(pop);
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (push) mem[wr_ptr] <= byte_data;
    end

    apb_master_xfer #(
        .ADDRESSWIDTH(ADDRESSWIDTH),
        .DATAWIDTH   (DATAWIDTH),
        .TIMEOUT     (TIMEOUT)
    ) u_xfer (
        .PCLK   (PCLK),
        .PRESETn(PRESETn),
        .go     (go),
        .addr   (go_addr),
        .wdata  (go_data),
        .free   (free),
        .ack    (ack),
        .timeout(timeout),
        .PADDR  (PADDR),
        .PWDATA (PWDATA),
        .PWRITE (PWRITE),
        .PSELx  (PSELx),
        .PENABLE(PENABLE),
        .PREADY (PREADY)
    );

endmodule

// File: tb/tb_apb_i2c_sequencer.sv
// Scoreboard bench for apb_i2c_sequencer: expected APB writes are queued at
// start, a monitor pops them on every completed ACCESS phase.
module tb_apb_i2c_sequencer;

    logic       PCLK = 1'b0;
    logic       PRESETn;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready;
    logic [3:0] fifo_level;
    logic       start;
    logic [7:0] slave_addr;
    logic       busy, done, error;
    logic [3:0] PADDR;
    logic [7:0] PWDATA;
    logic       PWRITE, PSELx, PENABLE;
    logic       PREADY;
    logic [7:0] PRDATA;

    always #5 PCLK = ~PCLK;

    apb_i2c_sequencer #(
        .ADDRESSWIDTH(4),
        .DATAWIDTH   (8),
        .DEPTH       (8),
        .TIMEOUT     (64)
    ) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .byte_ready(byte_ready),
        .fifo_level(fifo_level),
        .start     (start),
        .slave_addr(slave_addr),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PWRITE    (PWRITE),
        .PSELx     (PSELx),
        .PENABLE   (PENABLE),
        .PREADY    (PREADY),
        .PRDATA    (PRDATA)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [11:0] exp_q[$];
    logic [11:0] setup_val;

    int t0, d0;
    int done_cnt = 0, err_cnt = 0, psel_cnt = 0, busy_cnt = 0;
    int done_cyc = -1, err_cyc = -1;
    logic busy_at_done = 1'b1;

    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: samples mid-cycle, after the negedge stimulus has settled.
    always begin
        @(negedge PCLK);
        #2;
        if (PRESETn) begin
            if (PSELx) psel_cnt++;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc     = cyc;
                busy_at_done = busy;
            end
            if (error) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (PSELx && !PENABLE) setup_val = {PADDR, PWDATA};
            if (PSELx && PENABLE) begin
                check("apb_stable", {PADDR, PWDATA}, setup_val);
                check("apb_pwrite", PWRITE, 1'b1);
                if (PREADY) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL apb_extra: got %0h expected none",
                                 {PADDR, PWDATA});
                    end else begin
                        check("apb_write", {PADDR, PWDATA}, exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic load(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge PCLK);
            byte_valid = 1'b1;
            byte_data  = base + 8'(i);
        end
        @(negedge PCLK);
        byte_valid = 1'b0;
    endtask

    task automatic exp_seq(input logic [7:0] slv, input logic [7:0] base,
                           input int n);
        exp_q.push_back({4'd2, 8'hF6});
        exp_q.push_back({4'd6, slv});
        for (int i = 0; i < n; i++) exp_q.push_back({4'd4, base + 8'(i)});
        exp_q.push_back({4'd2, 8'hFC});
    endtask

    task automatic start_pulse(input logic [7:0] slv, input logic stray);
        @(negedge PCLK);
        start      = 1'b1;
        slave_addr = slv;
        byte_valid = stray;
        byte_data  = 8'h77;
        t0         = cyc;
        d0         = done_cnt;
        @(negedge PCLK);
        start      = 1'b0;
        byte_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_off);
        for (int i = 0; i < 200 && done_cnt == d0; i++) begin
            @(negedge PCLK);
            #3;
        end
        check({name, "_done_count"}, done_cnt - d0, 1);
        check({name, "_done_cycle"}, done_cyc - t0, exp_off);
        check({name, "_busy_at_done"}, busy_at_done, 1'b0);
        check({name, "_level_after"}, fifo_level, 4'd0);
        check({name, "_sb_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        int e0, p0, b0, k;
        PRESETn    = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        start      = 1'b0;
        slave_addr = 8'h00;
        PREADY     = 1'b1;
        PRDATA     = 8'h00;
        repeat (3) @(negedge PCLK);
        #2;
        check("rst_bus", {PADDR, PWDATA, PWRITE, PSELx, PENABLE}, 15'h0);
        check("rst_status", {busy, done, error}, 3'b000);
        check("rst_level", fifo_level, 4'd0);
        check("rst_byte_ready", byte_ready, 1'b1);
        @(negedge PCLK);
        PRESETn = 1'b1;

        // Eight bytes, bridge always ready.
        load(8'h00, 8);
        exp_seq(8'h20, 8'h00, 8);
        start_pulse(8'h20, 1'b0);
        wait_done("full8", 33);

        // One byte, three-cycle stall on the slave-address access.
        load(8'hA5, 1);
        exp_seq(8'h20, 8'hA5, 1);
        start_pulse(8'h20, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge PCLK);
            if (PSELx && !PENABLE && PADDR == 4'd6) begin
                PREADY = 1'b0;
                repeat (4) @(negedge PCLK);
                PREADY = 1'b1;
                break;
            end
        end
        wait_done("stall", 15);

        // Start with nothing buffered.
        e0 = err_cnt;
        p0 = psel_cnt;
        b0 = busy_cnt;
        start_pulse(8'h20, 1'b0);
        repeat (5) @(negedge PCLK);
        #3;
        check("empty_err_count", err_cnt - e0, 1);
        check("empty_err_cycle", err_cyc - t0, 1);
        check("empty_no_psel", psel_cnt - p0, 0);
        check("empty_no_busy", busy_cnt - b0, 0);

        // Overfill, then offer bytes while the sequence runs.
        load(8'h10, 9);
        #3;
        check("full_level", fifo_level, 4'd8);
        check("full_byte_ready", byte_ready, 1'b0);
        exp_seq(8'h33, 8'h10, 8);
        start_pulse(8'h33, 1'b0);
        byte_valid = 1'b1;
        byte_data  = 8'hEE;
        repeat (10) @(negedge PCLK);
        #3;
        check("busy_byte_ready", byte_ready, 1'b0);
        @(negedge PCLK);
        byte_valid = 1'b0;
        wait_done("overfill", 33);

        // Reset during the third data access.
        load(8'h40, 4);
        exp_q.push_back({4'd2, 8'hF6});
        exp_q.push_back({4'd6, 8'h55});
        exp_q.push_back({4'd4, 8'h40});
        exp_q.push_back({4'd4, 8'h41});
        start_pulse(8'h55, 1'b0);
        e0 = err_cnt;
        k  = 0;
        for (int i = 0; i < 60 && k < 3; i++) begin
            @(negedge PCLK);
            if (PSELx && PENABLE && PADDR == 4'd4) begin
                k++;
                if (k == 3) PRESETn = 1'b0;
            end
        end
        check("rst_hit_third", k, 3);
        @(negedge PCLK);
        check("midrst_bus", {PADDR, PWDATA, PWRITE, PSELx, PENABLE}, 15'h0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_level", fifo_level, 4'd0);
        PRESETn = 1'b1;
        repeat (6) @(negedge PCLK);
        #3;
        check("midrst_no_done", done_cnt - d0, 0);
        check("midrst_no_err", err_cnt - e0, 0);
        check("midrst_sb", exp_q.size(), 0);

`ifdef APB_SEQ_TIMEOUT_EN
        // Bridge never ready: watchdog aborts after 64 ACCESS cycles.
        load(8'h60, 2);
        PREADY = 1'b0;
        e0 = err_cnt;
        start_pulse(8'h21, 1'b0);
        for (int i = 0; i < 200 && err_cnt == e0; i++) begin
            @(negedge PCLK);
            #3;
        end
        check("to_err_count", err_cnt - e0, 1);
        check("to_err_cycle", err_cyc - t0, 66);
        check("to_bus_idle", {PSELx, PENABLE, busy}, 3'b000);
        check("to_flushed", fifo_level, 4'd0);
        check("to_no_done", done_cnt - d0, 0);
        PREADY = 1'b1;
        repeat (3) @(negedge PCLK);
`endif

        repeat (3) @(negedge PCLK);
        #3;
        check("final_sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
